// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// sequencing FSM state type and the datapath width.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RMW   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   i_word     : word read from data memory
//   i_wdata    : right-aligned store data
//   i_lane     : byte address bits [1:0]
//   i_size     : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_unsigned : zero-extend loads when set
//   o_load     : addressed lane of i_word, sign/zero extended
//   o_merged   : i_word with the addressed lane replaced by i_wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] word,
    input logic [DATA_W-1:0] wdata,
    input logic [1:0]        lane,
    input logic [1:0]        size
  );
    logic [DATA_W-1:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign o_load   = extract(i_word, i_lane, i_size, i_unsigned);
  assign o_merged = merge(i_word, i_wdata, i_lane, i_size);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-addressed data memory.
// Converts byte/half/word requests on byte addresses into word memory
// cycles; sub-word stores are read-modify-write.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : request handshake and fields (byte address)
//   resp_valid/err    : one-cycle completion pulse, error qualifier
//   resp_rdata        : extended load result (0 for stores/errors)
//   dm_*              : data memory port (word index, strobes, data)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] dm_address,
  output logic [31:0] dm_writedata,
  output logic        dm_memread,
  output logic        dm_memwrite,
  input  logic [31:0] dm_readdata
);

  state_t      r_state;
  logic        r_write;
  logic        r_unsigned;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [29:0] r_widx;
  logic [31:0] r_wdata;

  logic        w_hs;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = (r_state == ST_IDLE) && rst_n;
  assign w_hs      = req_valid && req_ready;

  assign w_err = (req_size == 2'b11)
              || ((req_size == SZ_HALF) && req_addr[0])
              || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
              || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Control state: the only registers touched by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            if (w_err)                        r_state <= ST_RESP;
            else if (!req_write)              r_state <= ST_READ;
            else if (req_size == SZ_WORD)     r_state <= ST_WRITE;
            else                              r_state <= ST_READ;
          end
        end
        ST_READ:  r_state <= r_write ? ST_RMW : ST_RESP;
        ST_WRITE: r_state <= ST_RESP;
        ST_RMW:   r_state <= ST_RESP;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Request capture at the handshake edge.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_write    <= req_write;
      r_unsigned <= req_unsigned;
      r_err      <= w_err;
      r_size     <= req_size;
      r_lane     <= req_addr[1:0];
      r_widx     <= req_addr[31:2];
      r_wdata    <= req_wdata;
    end
  end

  lsu_lane_align u_align (
    .i_word     (dm_readdata),
    .i_wdata    (r_wdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  // Memory-side and response muxing, decoded from state only.
  always_comb begin
    dm_address   = 32'b0;
    dm_writedata = 32'b0;
    dm_memread   = 1'b0;
    dm_memwrite  = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = 32'b0;
    case (r_state)
      ST_READ: begin
        dm_address = {2'b00, r_widx};
        dm_memread = 1'b1;
      end
      ST_WRITE: begin
        dm_address   = {2'b00, r_widx};
        dm_memwrite  = 1'b1;
        dm_writedata = r_wdata;
      end
      ST_RMW: begin
        // dm_readdata still holds the word fetched in READ.
        dm_address   = {2'b00, r_widx};
        dm_memwrite  = 1'b1;
        dm_writedata = w_merged;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_err || r_write) ? 32'b0 : w_load;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing stage between the execute-stage address/data outputs and the word-addressed data memory. Accepts byte, halfword and word load/store requests on byte addresses and converts them into single-word memory cycles: word accesses pass straight through, and sub-word stores become read-modify-write. Load results are extracted from the memory's registered read data and sign- or zero-extended. The unit flags misaligned and out-of-range accesses without touching memory.

## Interface
- DEPTH, 32, number of 32-bit words in the data memory. Word index must be < DEPTH.
- clk  in  1  rising-edge clock, shared with data memory.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request. High only in IDLE with rst_n high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size encoding, defined in lsu_pkg.
- req_unsigned  in  1  zero-extend loads; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse for every accepted request.
- resp_err  out  1  qualifies resp_valid; misaligned, illegal size or out of range.
- resp_rdata  out  32  load result; 0 for stores and errors.
- dm_address  out  32  word index to memory, {2'b00, addr[31:2]}.
- dm_writedata  out  32  word written to memory.
- dm_memread  out  1  memory read strobe.
- dm_memwrite  out  1  memory write strobe. Never asserted together with dm_memread.
- dm_readdata  in  32  memory read data, valid the cycle after dm_memread.

## Operation
- A handshake occurs when req_valid and req_ready are both high at a rising edge. The request fields are latched into internal registers at that edge.
- The FSM has five states: IDLE, READ, WRITE, RMW, RESP.
- Transitions out of IDLE:
  - Error request → RESP.
  - Load → READ.
  - Word store → WRITE.
  - Sub-word store → READ.
- Transitions out of the other states:
  - READ → RESP for a load.
  - READ → RMW for a sub-word store.
  - WRITE → RESP.
  - RMW → RESP.
  - RESP → IDLE.
- Error conditions:
  - Size is 2'b11.
  - Half access with addr[0] set.
  - Word access with addr[1:0] non-zero.
  - addr[31:2] ≥ DEPTH.
  - An error response never drives memread or memwrite.
- State outputs (all combinational from state and the latched registers):
  - READ: dm_memread=1.
  - WRITE: dm_memwrite=1, dm_writedata = latched wdata.
  - RMW: dm_memwrite=1, dm_writedata = dm_readdata with the addressed lane replaced. Lane byte = addr[1:0]; half = addr[1]. Byte ordering is little-endian.
  - RESP: resp_valid=1. For loads, resp_rdata = addressed lane of dm_readdata, extended per the latched unsigned bit.
- dm_address is held at the latched word index from READ through RMW. It is 0 in IDLE and RESP.

## Timing
- The handshake at edge E0 sets the latency for each access type:
  - Error: resp at cycle 1.
  - Load: READ at cycle 1, resp at cycle 2.
  - Word store: WRITE at cycle 1, resp at cycle 2.
  - Sub-word store: READ at cycle 1, RMW at cycle 2, resp at cycle 3.
- Throughput: one request per latency + 1 cycles. req_ready is low from E0 until the state returns to IDLE.
- There is no back-to-back acceptance in RESP; the next handshake is possible in the cycle after RESP.
- Reset values: state IDLE. All outputs 0, including req_ready while rst_n is low.
- Reset mid-operation: the next cycle is IDLE with no strobes and no resp_valid, and the in-flight request is dropped.
  - A sub-word store reset in READ leaves memory unchanged.
  - A reset in RMW or WRITE is sampled at the same edge as the write. The memory write at that edge still completes.
- req_valid while not ready is ignored. The request is not queued, so upstream must hold it until ready.

## Structure
- lsu_pkg holds the following shared definitions:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The state enum.
  - The data width constant, 32.
- The sub-module lsu_lane_align is purely combinational and has two functions:
  - extract(word, lane, size, unsigned) → 32-bit load value.
  - merge(word, wdata, lane, size) → 32-bit merged word.
- load_store_unit contains only the FSM, the request registers and the memory-side muxing.

## Test plan
- Against the data-memory model (word 1 = 84, word 2 = 11): lw addr 0x4 → resp_valid at cycle 2, rdata 0x00000054, err 0, exactly one memread.
- lb addr 0x8 → 0x0000000B; lh addr 0x6 → 0x00000000; size 2'b11 → err at cycle 1 with no strobes.
- sb 0xFF to addr 0x5 → READ then RMW, memory word 1 becomes 0x0000FF54, resp at cycle 3.
- Follow-up loads on addr 0x5: lb → 0xFFFFFFFF; lbu → 0x000000FF. Then sw 0x12345678 at addr 0x8 → word 2 = 0x12345678 after one memwrite; lhu addr 0xA → 0x00001234.
- Error cases: lw addr 0x6 → resp_err=1, rdata 0, no memread; sh addr 0x3 → err; lw addr 0x80 (index 32 ≥ DEPTH) → err; memory unchanged in all three.
- Reset cases:
  - rst_n low during READ of sb 0xAA to addr 0x4 → next cycle IDLE, no memwrite, word 1 unchanged (0x00000054), no resp_valid.
  - Holding req_valid during reset → no acceptance until rst_n high.
